// File: rtl/arbitro_ponderado_pkg.sv
// Shared types, widths and reset constants for the weighted round-robin
// FIFO arbiter and its wrap-around search helper.
package arbitro_ponderado_pkg;

    localparam int N_SRC = 4;
    localparam int IDX_W = 2;
    localparam int W_W   = 4;
    localparam int CFG_W = N_SRC * W_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_STALL = 2'd2
    } estado_e;

    localparam logic [W_W-1:0]   W_RST_0 = 4'd4;
    localparam logic [W_W-1:0]   W_RST_1 = 4'd3;
    localparam logic [W_W-1:0]   W_RST_2 = 4'd2;
    localparam logic [W_W-1:0]   W_RST_3 = 4'd1;
    localparam logic [CFG_W-1:0] WEIGHTS_RST = {W_RST_3, W_RST_2, W_RST_1, W_RST_0};

    // A programmed weight of zero still grants one pop per turn.
    function automatic logic [W_W-1:0] peso_efectivo(input logic [CFG_W-1:0] pesos,
                                                     input logic [IDX_W-1:0] idx);
        logic [W_W-1:0] w;
        w = pesos[{idx, 2'b00} +: W_W];
        return (w == 4'd0) ? 4'd1 : w;
    endfunction

    function automatic logic [N_SRC-1:0] onehot4(input logic [IDX_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/arbitro_ponderado_busca.sv
// Wrap-around search: first set bit of req_i at or after start_i (mod 4).
module busca_siguiente
    import arbitro_ponderado_pkg::*;
(
    input  logic [N_SRC-1:0] req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand_s;

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx_o   = start_i;
        valid_o = 1'b0;
        cand_s  = start_i;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            cand_s  = start_i + 2'(k);
            idx_o   = req_i[cand_s] ? cand_s : idx_o;
            valid_o = valid_o | req_i[cand_s];
        end
    end

endmodule

// File: rtl/arbitro_ponderado.sv
// Weighted round-robin arbiter popping four source FIFOs and pushing each
// popped word one cycle later into the destination FIFO named by dest.
module arbitro_ponderado
    import arbitro_ponderado_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_SRC-1:0] fifo_empty,
    input  logic [N_SRC-1:0] almost_full,
    input  logic [IDX_W-1:0] dest,
    input  logic             cfg_load,
    input  logic [CFG_W-1:0] weight_cfg,
    output logic [N_SRC-1:0] pops,
    output logic [N_SRC-1:0] push,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy
);

    estado_e          state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [W_W-1:0]   credit_q, credit_d;
    logic [CFG_W-1:0] weights_q, weights_d;
    logic [N_SRC-1:0] pops_q, pops_d;
    logic [N_SRC-1:0] push_q, push_d;
    logic             pend_q, pend_d;
    logic             busy_q, busy_d;

    logic [N_SRC-1:0] req_s;
    logic [IDX_W-1:0] sig_idx_s;
    logic             sig_val_s;
    logic [IDX_W-1:0] ini_idx_s;
    logic             ini_val_s;

    assign req_s = ~fifo_empty;

    // Next holder after the current grant (used when a turn ends).
    busca_siguiente u_busca_sig (
        .req_i   (req_s),
        .start_i (grant_q + 2'd1),
        .idx_o   (sig_idx_s),
        .valid_o (sig_val_s)
    );

    // Holder when leaving IDLE without a live turn: current index counts.
    busca_siguiente u_busca_ini (
        .req_i   (req_s),
        .start_i (grant_q),
        .idx_o   (ini_idx_s),
        .valid_o (ini_val_s)
    );

    // Next-state, grant/credit bookkeeping and registered output values.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        credit_d  = credit_q;
        weights_d = weights_q;
        pops_d    = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (enable && cfg_load) begin
                    weights_d = weight_cfg;
                end else begin
                    weights_d = weights_q;
                end
                if (enable && ini_val_s) begin
                    state_d = ST_SERVE;
                    // A turn interrupted by enable=0 resumes with its credit.
                    if ((credit_q != 4'd0) && req_s[grant_q]) begin
                        grant_d  = grant_q;
                        credit_d = credit_q;
                    end else begin
                        grant_d  = ini_idx_s;
                        credit_d = peso_efectivo(weights_q, ini_idx_s);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!sig_val_s) begin
                    state_d  = ST_IDLE;
                    credit_d = 4'd0;
                end else if (|almost_full) begin
                    state_d = ST_STALL;
                end else if (!req_s[grant_q]) begin
                    grant_d  = sig_idx_s;
                    credit_d = peso_efectivo(weights_q, sig_idx_s);
                end else begin
                    pops_d = onehot4(grant_q);
                    if (credit_q <= 4'd1) begin
                        grant_d  = sig_idx_s;
                        credit_d = peso_efectivo(weights_q, sig_idx_s);
                    end else begin
                        credit_d = credit_q - 4'd1;
                    end
                end
            end
            ST_STALL: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!sig_val_s) begin
                    state_d  = ST_IDLE;
                    credit_d = 4'd0;
                end else if (almost_full == 4'b0000) begin
                    state_d = ST_SERVE;
                end else begin
                    state_d = ST_STALL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        pend_d = (pops_d != 4'b0000);
        push_d = pend_q ? onehot4(dest) : 4'b0000;
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset overrides everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'd0;
            credit_q  <= 4'd0;
            weights_q <= WEIGHTS_RST;
            pops_q    <= 4'b0000;
            push_q    <= 4'b0000;
            pend_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            credit_q  <= credit_d;
            weights_q <= weights_d;
            pops_q    <= pops_d;
            push_q    <= push_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
        end
    end

    assign pops      = pops_q;
    assign push      = push_q;
    assign grant_idx = grant_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_arbitro_ponderado.sv
// Scoreboard bench for arbitro_ponderado: expected pops/push are queued as
// stimulus is driven and compared one cycle at a time.
module tb_arbitro_ponderado;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] fifo_empty;
    logic [3:0] almost_full;
    logic [1:0] dest;
    logic       cfg_load;
    logic [15:0] weight_cfg;
    logic [3:0] pops;
    logic [3:0] push;
    logic [1:0] grant_idx;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_pops_q [$];
    logic [3:0] exp_push_q [$];
    logic [3:0] last_pops;

    arbitro_ponderado dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .almost_full (almost_full),
        .dest        (dest),
        .cfg_load    (cfg_load),
        .weight_cfg  (weight_cfg),
        .pops        (pops),
        .push        (push),
        .grant_idx   (grant_idx),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a random dest, queue expectations for the coming edge, advance.
    task automatic cyc(input logic [3:0] exp_pops);
        logic [1:0] d;
        d = 2'($urandom_range(0, 3));
        dest = d;
        exp_push_q.push_back((last_pops != 4'b0000) ? (4'b0001 << d) : 4'b0000);
        exp_pops_q.push_back(exp_pops);
        last_pops = exp_pops;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; cfg_load = 1'b0; weight_cfg = 16'h0000;
        fifo_empty = 4'b1111; almost_full = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        last_pops = 4'b0000;
        exp_pops_q.delete();
        exp_push_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; cfg_load = 1'b1; weight_cfg = 16'hFFFF;
        fifo_empty = 4'b0000; almost_full = 4'b0000; dest = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pops !== 4'b0000) begin failures++; $display("FAIL reset_pops got=%b exp=0000", pops); end
        checks++; if (push !== 4'b0000) begin failures++; $display("FAIL reset_push got=%b exp=0000", push); end
        checks++; if (grant_idx !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", grant_idx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0; enable = 1'b0; cfg_load = 1'b0; fifo_empty = 4'b1111;
        last_pops = 4'b0000;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
    endtask

    // Runs right after test_reset: also shows cfg_load under reset was ignored.
    task automatic test_rotation();
        logic [3:0] ep, eh;
        int wts [4] = '{4, 3, 2, 1};
        int n = 0;
        fifo_empty = 4'b0000; almost_full = 4'b0000; enable = 1'b1;
        cyc(4'b0000);
        ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
        checks++; if (pops !== ep) begin failures++; $display("FAIL rot_start_pops got=%b exp=%b", pops, ep); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rot_start_busy got=%b exp=1", busy); end
        checks++; if (grant_idx !== 2'd0) begin failures++; $display("FAIL rot_start_grant got=%0d exp=0", grant_idx); end
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 4; s++) begin
                for (int k = 0; k < wts[s]; k++) begin
                    cyc(4'b0001 << s);
                    ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
                    checks++; if (pops !== ep) begin failures++; $display("FAIL rot_pops[%0d] got=%b exp=%b", n, pops, ep); end
                    checks++; if (push !== eh) begin failures++; $display("FAIL rot_push[%0d] got=%b exp=%b", n, push, eh); end
                    n++;
                end
            end
        end
        fifo_empty = 4'b1111;
        cyc(4'b0000);
        ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
        checks++; if (pops !== ep) begin failures++; $display("FAIL rot_end_pops got=%b exp=%b", pops, ep); end
        checks++; if (push !== eh) begin failures++; $display("FAIL rot_end_push got=%b exp=%b", push, eh); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rot_end_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_source();
        logic [3:0] ep, eh;
        do_reset();
        fifo_empty = 4'b1011; enable = 1'b1;
        cyc(4'b0000);
        ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
        checks++; if (grant_idx !== 2'd2) begin failures++; $display("FAIL single_start_grant got=%0d exp=2", grant_idx); end
        for (int i = 0; i < 8; i++) begin
            cyc(4'b0100);
            ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
            checks++; if (pops !== ep) begin failures++; $display("FAIL single_pops[%0d] got=%b exp=%b", i, pops, ep); end
            checks++; if (push !== eh) begin failures++; $display("FAIL single_push[%0d] got=%b exp=%b", i, push, eh); end
            checks++; if (grant_idx !== 2'd2) begin failures++; $display("FAIL single_grant[%0d] got=%0d exp=2", i, grant_idx); end
        end
    endtask

    task automatic test_stall();
        logic [3:0] ep, eh;
        logic [3:0] seq [10] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
                                 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010};
        do_reset();
        fifo_empty = 4'b0000; enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            almost_full = (i >= 3 && i <= 5) ? 4'b0010 : 4'b0000;
            cyc(seq[i]);
            ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
            checks++; if (pops !== ep) begin failures++; $display("FAIL stall_pops[%0d] got=%b exp=%b", i, pops, ep); end
            checks++; if (push !== eh) begin failures++; $display("FAIL stall_push[%0d] got=%b exp=%b", i, push, eh); end
            if (i >= 3 && i <= 5) begin
                checks++; if (grant_idx !== 2'd0) begin failures++; $display("FAIL stall_grant[%0d] got=%0d exp=0", i, grant_idx); end
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy[%0d] got=%b exp=1", i, busy); end
            end
        end
    endtask

    task automatic test_enable_hold();
        logic [3:0] ep, eh;
        logic [3:0] seq [8] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000,
                                4'b0000, 4'b0000, 4'b0001, 4'b0001};
        do_reset();
        fifo_empty = 4'b0000;
        for (int i = 0; i < 9; i++) begin
            enable = (i == 3 || i == 4) ? 1'b0 : 1'b1;
            cyc((i < 8) ? seq[i] : 4'b0010);
            ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
            checks++; if (pops !== ep) begin failures++; $display("FAIL en_pops[%0d] got=%b exp=%b", i, pops, ep); end
            checks++; if (push !== eh) begin failures++; $display("FAIL en_push[%0d] got=%b exp=%b", i, push, eh); end
            if (i == 3 || i == 4) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL en_busy[%0d] got=%b exp=0", i, busy); end
                checks++; if (grant_idx !== 2'd0) begin failures++; $display("FAIL en_grant[%0d] got=%0d exp=0", i, grant_idx); end
            end
        end
    endtask

    task automatic test_cfg_load();
        logic [3:0] ep, eh;
        int wts [4] = '{4, 3, 2, 1};
        int n = 0;
        do_reset();
        fifo_empty = 4'b0000; enable = 1'b1;
        cyc(4'b0000);
        ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
        cfg_load = 1'b1; weight_cfg = 16'h1111;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < wts[s]; k++) begin
                cyc(4'b0001 << s);
                ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
                checks++; if (pops !== ep) begin failures++; $display("FAIL cfg_serve_pops[%0d] got=%b exp=%b", n, pops, ep); end
                n++;
            end
        end
        fifo_empty = 4'b1111;
        cyc(4'b0000);
        ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
        checks++; if (push !== eh) begin failures++; $display("FAIL cfg_drain_push got=%b exp=%b", push, eh); end
        cyc(4'b0000);
        ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
        cfg_load = 1'b0; fifo_empty = 4'b0000;
        cyc(4'b0000);
        ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
        for (int i = 0; i < 8; i++) begin
            cyc(4'b0001 << (i % 4));
            ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
            checks++; if (pops !== ep) begin failures++; $display("FAIL cfg_idle_pops[%0d] got=%b exp=%b", i, pops, ep); end
            checks++; if (push !== eh) begin failures++; $display("FAIL cfg_idle_push[%0d] got=%b exp=%b", i, push, eh); end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] ep, eh;
        logic [3:0] seq [6] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        do_reset();
        enable = 1'b1; cfg_load = 1'b1; weight_cfg = 16'h1111;
        cyc(4'b0000);
        ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
        cfg_load = 1'b0; fifo_empty = 4'b0000;
        cyc(4'b0000);
        ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
        cyc(4'b0001);
        ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
        checks++; if (pops !== ep) begin failures++; $display("FAIL rmid_pop got=%b exp=%b", pops, ep); end
        dest = 2'd3; reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; last_pops = 4'b0000;
        checks++; if (push !== 4'b0000) begin failures++; $display("FAIL rmid_push got=%b exp=0000", push); end
        checks++; if (pops !== 4'b0000) begin failures++; $display("FAIL rmid_pops got=%b exp=0000", pops); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if (grant_idx !== 2'd0) begin failures++; $display("FAIL rmid_grant got=%0d exp=0", grant_idx); end
        for (int i = 0; i < 6; i++) begin
            cyc(seq[i]);
            ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
            checks++; if (pops !== ep) begin failures++; $display("FAIL rmid_after_pops[%0d] got=%b exp=%b", i, pops, ep); end
            checks++; if (push !== eh) begin failures++; $display("FAIL rmid_after_push[%0d] got=%b exp=%b", i, push, eh); end
        end
    endtask

    task automatic test_zero_weights();
        logic [3:0] ep, eh;
        logic [3:0] rot [3] = '{4'b0001, 4'b0100, 4'b1000};
        do_reset();
        enable = 1'b1; cfg_load = 1'b1; weight_cfg = 16'h0000;
        cyc(4'b0000);
        ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
        cfg_load = 1'b0; fifo_empty = 4'b0010;
        cyc(4'b0000);
        ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
        for (int i = 0; i < 9; i++) begin
            cyc(rot[i % 3]);
            ep = exp_pops_q.pop_front(); eh = exp_push_q.pop_front();
            checks++; if (pops !== ep) begin failures++; $display("FAIL zero_pops[%0d] got=%b exp=%b", i, pops, ep); end
            checks++; if (push !== eh) begin failures++; $display("FAIL zero_push[%0d] got=%b exp=%b", i, push, eh); end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; fifo_empty = 4'b1111; almost_full = 4'b0000;
        dest = 2'd0; cfg_load = 1'b0; weight_cfg = 16'h0000; last_pops = 4'b0000;
        test_reset();
        test_rotation();
        test_single_source();
        test_stall();
        test_enable_hold();
        test_cfg_load();
        test_reset_mid();
        test_zero_weights();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arbitro_ponderado.md
ARBITRO_PONDERADO -- requirements
Module: arbitro_ponderado

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk and reset; all state updates on posedge clk only.
REQ-002 Port list SHALL be:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- enable  in  1  arbitration enable; low freezes state, outputs forced 0
- fifo_empty  in  4  empty flags of source FIFOs 0..3
- almost_full  in  4  almost-full flags of destination FIFOs 0..3
- dest  in  2  destination field of the word popped in the previous cycle
- cfg_load  in  1  load weight_cfg into weight registers
- weight_cfg  in  16  four 4-bit weights, source i at bits [4i+3:4i]
- pops  out  4  one-hot pop to source FIFOs, registered
- push  out  4  one-hot push to destination FIFOs, registered
- grant_idx  out  2  source currently holding the grant
- busy  out  1  high in SERVE or STALL

Function
REQ-003 FSM SHALL have states IDLE, SERVE, STALL.
REQ-004 IDLE->SERVE when enable=1 and fifo_empty!=4'b1111; SERVE->STALL when |almost_full; STALL->SERVE when almost_full==0 and a source is non-empty; SERVE/STALL->IDLE when all sources empty or enable=0.
REQ-005 In SERVE, pops SHALL be one-hot at grant_idx if fifo_empty[grant_idx]=0; otherwise pops=0 that cycle and the grant moves.
REQ-006 In IDLE and STALL, pops SHALL be 4'b0000.
REQ-007 Weighted round robin: on taking a grant, a 4-bit credit counter SHALL load weight[grant_idx] (weight 0 treated as 1); each pop decrements credit.
REQ-008 The grant SHALL move when credit reaches 0 after a pop, or when the granted source is empty; next grant = first non-empty source searching (grant_idx+1) mod 4 upward with wrap-around; credit reloads in the same cycle.
REQ-009 If only the granted source is non-empty when credit expires, it SHALL be re-granted with a fresh credit, with no bubble cycle.
REQ-010 Push latency: if pops!=0 in cycle N, push in cycle N+1 SHALL be the one-hot of dest sampled in N+1; otherwise push=0.
REQ-011 A pending push SHALL complete even if STALL, IDLE or enable=0 is entered in cycle N+1; no popped word is ever dropped.
REQ-012 STALL SHALL preserve grant_idx and credit; SERVE resumes at the same source with the remaining credit.
REQ-013 cfg_load SHALL take effect only in IDLE; it is ignored in SERVE/STALL. New weights apply from the next grant.
REQ-014 enable=0 SHALL hold grant_idx, credit and weights; pops=0 and busy=0 while low (except REQ-011).
REQ-015 busy SHALL be a registered decode of state (SERVE or STALL).

Reset
REQ-016 While reset=1 at posedge: state=IDLE, pops=0, push=0, grant_idx=0, credit=0, busy=0, pending-push flag cleared, weights={1,2,3,4} for sources {3,2,1,0}.
REQ-017 Reset mid-operation SHALL discard any pending push (push=0 on the cycle after reset).
REQ-018 Reset SHALL have priority over enable and cfg_load.

Structure
REQ-019 State encodings, reset weight constants (4,3,2,1) and port widths SHALL live in a shared package/include file for the transaction layer.
REQ-020 The wrap-around next-non-empty search SHALL be a separate combinational sub-module, busca_siguiente (inputs: 4-bit request vector, 2-bit start index; outputs: 2-bit index, valid).
REQ-021 Target size: 120-400 lines of RTL total.

Verification
REQ-022 All sources full, almost_full=0, reset weights, 20 cycles -> pops sequence 0001x4, 0010x3, 0100x2, 1000x1, repeating; push follows one cycle later per dest.
REQ-023 Only source 2 non-empty, weight 2 -> pops=0100 every cycle, no bubble at credit reload (REQ-009); grant_idx stays 2.
REQ-024 almost_full=0010 asserted mid-burst at source 0 after 2 pops -> pops=0 next cycle, pending push still issued; on release source 0 pops exactly 2 more before moving to source 1.
REQ-025 cfg_load with weight_cfg=16'h1111 during SERVE -> ignored (4,3,2,1 pattern persists); same load in IDLE -> strict 1:1:1:1 rotation afterwards.
REQ-026 reset asserted the cycle after a pop with dest=3 -> push=0000 next cycle, all outputs at reset values, weights back to 4,3,2,1.
REQ-027 Source 1 empty, others full, weight_cfg=16'h0000 loaded -> rotation 0,2,3,0,... one pop each (weight 0 treated as 1), source 1 never popped.
